// File: rtl/cpu_decode_scoreboard_pkg.sv
// Shared SLURM32 decode definitions: instruction-class patterns, field
// extraction, link register numbers and the class helper predicates.
package cpu_decode_scoreboard_pkg;

    localparam int unsigned INS_BITS = 32;
    localparam int unsigned SEL_BITS = 8;

    localparam logic [SEL_BITS-1:0] LINK_REGISTER           = 8'd15;
    localparam logic [SEL_BITS-1:0] INTERRUPT_LINK_REGISTER = 8'd14;

    // Instruction-class patterns; class lives in [31:28], sub-op in [27:24].
    // Fields: dest/store-data [23:16], src/base/branch-index [15:8], src2 [7:0].
    localparam logic [INS_BITS-1:0] INS_RET        = 32'h01??????;
    localparam logic [INS_BITS-1:0] INS_IRET       = 32'h02??????;
    localparam logic [INS_BITS-1:0] INS_ALU_SINGLE = 32'h1???????;
    localparam logic [INS_BITS-1:0] INS_ALU_RR     = 32'h2???????;
    localparam logic [INS_BITS-1:0] INS_COND_ALU   = 32'h3???????;
    localparam logic [INS_BITS-1:0] INS_ALU_IMM    = 32'h4???????;
    localparam logic [INS_BITS-1:0] INS_BRANCH     = 32'h5???????;
    localparam logic [INS_BITS-1:0] INS_LOAD       = 32'h6???????;
    localparam logic [INS_BITS-1:0] INS_STORE      = 32'h7???????;

    typedef enum logic [3:0] {
        CLS_NONE,
        CLS_RET,
        CLS_IRET,
        CLS_ALU_SINGLE,
        CLS_ALU_RR,
        CLS_COND_ALU,
        CLS_ALU_IMM,
        CLS_BRANCH,
        CLS_LOAD,
        CLS_STORE
    } ins_class_t;

    typedef struct packed {
        logic [SEL_BITS-1:0] sel_a;
        logic [SEL_BITS-1:0] sel_b;
        logic [SEL_BITS-1:0] dest;
        logic                dest_wr;
        logic                load;
    } decode_t;

    function automatic ins_class_t ins_class(input logic [INS_BITS-1:0] ins);
        ins_class_t c;
        casez (ins)
            INS_RET:        c = CLS_RET;
            INS_IRET:       c = CLS_IRET;
            INS_ALU_SINGLE: c = CLS_ALU_SINGLE;
            INS_ALU_RR:     c = CLS_ALU_RR;
            INS_COND_ALU:   c = CLS_COND_ALU;
            INS_ALU_IMM:    c = CLS_ALU_IMM;
            INS_BRANCH:     c = CLS_BRANCH;
            INS_LOAD:       c = CLS_LOAD;
            INS_STORE:      c = CLS_STORE;
            default:        c = CLS_NONE;
        endcase
        return c;
    endfunction

    function automatic logic [SEL_BITS-1:0] fld_dest(input logic [INS_BITS-1:0] ins);
        return SEL_BITS'(ins >> 16);
    endfunction

    function automatic logic [SEL_BITS-1:0] fld_src(input logic [INS_BITS-1:0] ins);
        return SEL_BITS'(ins >> 8);
    endfunction

    function automatic logic [SEL_BITS-1:0] fld_src2(input logic [INS_BITS-1:0] ins);
        return SEL_BITS'(ins);
    endfunction

    function automatic logic is_ret_or_iret(input ins_class_t c);
        return (c == CLS_RET) || (c == CLS_IRET);
    endfunction

    function automatic logic is_load(input ins_class_t c);
        return c == CLS_LOAD;
    endfunction

    function automatic logic is_store(input ins_class_t c);
        return c == CLS_STORE;
    endfunction

    // Branch-and-link is flagged by bit 27 of a branch.
    function automatic logic is_branch_link(input logic [INS_BITS-1:0] ins);
        return (ins_class(ins) == CLS_BRANCH) && ins[27];
    endfunction

    function automatic decode_t decode(input logic [INS_BITS-1:0] ins);
        decode_t    d;
        ins_class_t c;
        d = '0;
        c = ins_class(ins);
        if (is_ret_or_iret(c)) begin
            d.sel_a = (c == CLS_IRET) ? INTERRUPT_LINK_REGISTER : LINK_REGISTER;
        end
        if (is_store(c)) begin
            d.sel_a = fld_src(ins);
            d.sel_b = fld_dest(ins);
        end
        if (is_load(c)) begin
            d.sel_a   = fld_src(ins);
            d.dest    = fld_dest(ins);
            d.dest_wr = 1'b1;
            d.load    = 1'b1;
        end
        case (c)
            CLS_ALU_SINGLE: begin
                d.sel_b   = fld_src2(ins);
                d.dest    = fld_dest(ins);
                d.dest_wr = 1'b1;
            end
            CLS_ALU_RR: begin
                d.sel_a   = fld_src(ins);
                d.sel_b   = fld_src2(ins);
                d.dest    = fld_dest(ins);
                d.dest_wr = 1'b1;
            end
            CLS_COND_ALU: begin
                d.sel_a   = fld_dest(ins);
                d.sel_b   = fld_src2(ins);
                d.dest    = fld_dest(ins);
                d.dest_wr = 1'b1;
            end
            CLS_ALU_IMM: begin
                d.sel_a   = fld_src(ins);
                d.dest    = fld_dest(ins);
                d.dest_wr = 1'b1;
            end
            CLS_BRANCH: begin
                d.sel_a = fld_src(ins);
                if (is_branch_link(ins)) begin
                    d.dest    = LINK_REGISTER;
                    d.dest_wr = 1'b1;
                end
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cpu_decode_scoreboard_scoreboard.sv
// In-flight destination tracker: a PIPE_DEPTH-deep shift register of
// {valid, reg, load} with read-after-write match against two sources.
module cpu_scoreboard
    import cpu_decode_scoreboard_pkg::*;
#(
    parameter int PIPE_DEPTH    = 3,
    parameter int REGISTER_BITS = 8,
    parameter int FORWARD       = 1
) (
    input  logic                     CLK,
    input  logic                     RSTb,
    input  logic                     push_valid,
    input  logic [REGISTER_BITS-1:0] push_reg,
    input  logic                     push_load,
    input  logic                     flush,
    input  logic [REGISTER_BITS-1:0] src_a,
    input  logic [REGISTER_BITS-1:0] src_b,
    output logic                     match
);

    typedef struct packed {
        logic                     valid;
        logic [REGISTER_BITS-1:0] rsel;
        logic                     load;
    } entry_t;

    entry_t sb [PIPE_DEPTH];

    // Shift entries toward writeback; a flush kills the squashed slot-0 entry on its way out.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
                sb[k] <= '0;
            end
        end else begin
            sb[0] <= '{valid: push_valid, rsel: push_reg, load: push_load};
            for (int unsigned k = 1; k < PIPE_DEPTH; k++) begin
                sb[k] <= sb[k-1];
            end
            if (flush) begin
                sb[1].valid <= 1'b0;
            end
        end
    end

    // With forwarding only a load in slot 0 is uncoverable; otherwise any pending write blocks.
    always_comb begin
        match = 1'b0;
        for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
            if (sb[k].valid && ((FORWARD == 0) || ((k == 0) && sb[k].load))) begin
                if (((src_a != '0) && (src_a == sb[k].rsel)) ||
                    ((src_b != '0) && (src_b == sb[k].rsel))) begin
                    match = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cpu_decode_scoreboard.sv
// Registered SLURM32 decode stage with hazard scoreboard and flush support.
module cpu_decode_scoreboard
    import cpu_decode_scoreboard_pkg::*;
#(
    parameter int BITS          = 32,
    parameter int REGISTER_BITS = 8,
    parameter int PIPE_DEPTH    = 3,
    parameter int FORWARD       = 1
) (
    input  logic                     CLK,
    input  logic                     RSTb,
    input  logic [BITS-1:0]          instruction,
    input  logic                     ins_valid,
    output logic                     ins_ready,
    input  logic                     flush,
    output logic                     out_valid,
    output logic [REGISTER_BITS-1:0] regA_sel,
    output logic [REGISTER_BITS-1:0] regB_sel,
    output logic [REGISTER_BITS-1:0] dest_sel,
    output logic                     dest_wr,
    output logic                     is_load,
    output logic                     hazard
);

    logic [INS_BITS-1:0]      ins;
    decode_t                  dec;
    logic [REGISTER_BITS-1:0] dec_a;
    logic [REGISTER_BITS-1:0] dec_b;
    logic [REGISTER_BITS-1:0] dec_dest;
    logic                     match;
    logic                     accept;
    logic                     push_valid;

    assign ins      = INS_BITS'(instruction);
    assign dec      = decode(ins);
    assign dec_a    = REGISTER_BITS'(dec.sel_a);
    assign dec_b    = REGISTER_BITS'(dec.sel_b);
    assign dec_dest = REGISTER_BITS'(dec.dest);

    assign hazard     = ins_valid && match;
    assign ins_ready  = !hazard && !flush;
    assign accept     = ins_valid && ins_ready;
    assign push_valid = accept && dec.dest_wr && (dec_dest != '0);

    cpu_scoreboard #(
        .PIPE_DEPTH    (PIPE_DEPTH),
        .REGISTER_BITS (REGISTER_BITS),
        .FORWARD       (FORWARD)
    ) u_scoreboard (
        .CLK        (CLK),
        .RSTb       (RSTb),
        .push_valid (push_valid),
        .push_reg   (dec_dest),
        .push_load  (dec.load),
        .flush      (flush),
        .src_a      (dec_a),
        .src_b      (dec_b),
        .match      (match)
    );

    // Output register: load decode on accept, otherwise insert a bubble and hold selects.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            out_valid <= 1'b0;
            regA_sel  <= '0;
            regB_sel  <= '0;
            dest_sel  <= '0;
            dest_wr   <= 1'b0;
            is_load   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            regA_sel  <= dec_a;
            regB_sel  <= dec_b;
            dest_sel  <= dec_dest;
            dest_wr   <= dec.dest_wr;
            is_load   <= dec.load;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/cpu_decode_scoreboard.md
Name: cpu_decode_scoreboard

Overview:
- Registered decode stage for the SLURM32 pipeline; successor to the combinational register-select decoder.
- Decodes register read selects (A/B) and the destination register of each accepted instruction, then holds them in an output register for execute.
- Tracks in-flight destination writes in a PIPE_DEPTH-entry scoreboard. Stalls issue on read-after-write hazards that forwarding cannot cover.
- Supports flush from branch resolution.

Parameters:
- BITS, 32, instruction width
- REGISTER_BITS, 8, register select width
- PIPE_DEPTH, 3, in-flight slots from decode output to writeback (min 2)
- FORWARD, 1, 1 = execute forwarding present (stall only on load-use); 0 = stall on any pending write

Ports:
- CLK  in  1  clock
- RSTb  in  1  asynchronous active-low reset
- instruction  in  BITS  instruction from fetch
- ins_valid  in  1  instruction valid
- ins_ready  out  1  decode accepts instruction this cycle
- flush  in  1  squash instruction in decode output register
- out_valid  out  1  decode output register holds a live instruction
- regA_sel  out  REGISTER_BITS  registered read select A
- regB_sel  out  REGISTER_BITS  registered read select B
- dest_sel  out  REGISTER_BITS  registered destination select
- dest_wr  out  1  output instruction writes dest_sel
- is_load  out  1  output instruction is a memory load
- hazard  out  1  combinational: incoming valid instruction blocked by scoreboard

Behaviour:
- Reset (async, RSTb=0): out_valid, regA_sel, regB_sel, dest_sel, dest_wr, is_load all 0. All scoreboard entries invalid. Takes effect immediately, including mid-stall.
- Combinational decode uses the shared decode functions and instruction classes:
  - ret/iret: A = LINK_REGISTER or INTERRUPT_LINK_REGISTER.
  - alu single reg: B = src2, dest = dest.
  - alu reg/reg: A = src, B = src2, dest = dest.
  - cond alu reg/reg: A = dest, B = src2, dest = dest.
  - alu reg/imm: A = src, dest = dest.
  - branch: A = branch index reg; dest_wr = 1 with dest = LINK_REGISTER only for branch-and-link.
  - load: A = base, dest = dest, is_load = 1.
  - store: A = base, B = data, no dest.
  - default: selects 0, no dest.
- Register 0 is never a hazard source. A dest of 0 is not recorded.
- Scoreboard entry k = {valid, reg, load}. Entry 0 belongs to the instruction currently in the output register.
- Hazard check against incoming srcA/srcB (non-zero):
  - FORWARD=0: match against any valid entry 0..PIPE_DEPTH-1.
  - FORWARD=1: match only against entry 0 with load=1.
- ins_ready = !hazard && !flush. hazard = ins_valid && match.
- Every posedge, entry k -> entry k+1; the last entry retires.
- Entry 0 loading:
  - On accept: entry 0 <= {dest_wr&&dest!=0, dest, is_load}; output register loads decode; out_valid <= 1.
  - Otherwise (stall, flush, or no valid): bubble; out_valid <= 0; entry 0 invalid; selects hold their previous values.
- Flush: the entry being shifted out of slot 0 is written to slot 1 as invalid. The squashed instruction never reaches writeback tracking. No accept occurs that cycle.
- Simultaneous flush and hazard: flush dominates (bubble, entry 1 invalid).
- Latency: 1 cycle from accept to out_valid. Throughput 1/cycle absent hazards.
- Stall duration: FORWARD=0 hazard on entry 0 is PIPE_DEPTH cycles; FORWARD=1 load-use is 1 cycle.

Decomposition:
- Shared package/include: instruction-class casex constants, field extract functions, LINK_REGISTER, INTERRUPT_LINK_REGISTER, is_ret_or_iret, new is_load/is_store/is_branch_link helpers.
- One sub-module: cpu_scoreboard (shift register plus match logic, parameterised by PIPE_DEPTH, REGISTER_BITS, FORWARD).

Test Plan:
- Reset mid-stream: RSTb low during a stall -> all outputs 0 and ins_ready=1 next cycle with a non-hazard instruction.
- FORWARD=1: load r5 then alu r6=r5+r7 back-to-back -> hazard=1 for exactly 1 cycle, second instruction out_valid 2 cycles after the load.
- FORWARD=0, PIPE_DEPTH=3: alu r3 then alu reading r3 -> stalled 3 cycles, then accepted. Reading r4 instead -> no stall.
- Writes to r0 then reads of r0 -> hazard never asserts.
- Load r5 accepted, then flush next cycle while dependent alu waits -> out_valid=0, entry1 invalid, dependent accepted with no further stall (FORWARD=0).
- ret then iret -> regA_sel=LINK_REGISTER then INTERRUPT_LINK_REGISTER. Store r2,[r9] -> A=9, B=2, dest_wr=0.
